serial_adder_ctrl: RTL

//  Bit-serial adder controller; the stage directly upstream of the single-bit full adder unit.
//  - Loads two WIDTH-bit operands on start.
//  - Presents one bit pair plus the stored carry to the full adder each cycle, LSB first.
//  - Captures the returned sum/carry bits into a result shift register and carry flop.
//  - Pulses done when the WIDTH-bit sum and final carry-out are valid.

---
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one operand bit pair plus carry per cycle to an
// external full adder, LSB first, and collects the returned sum/carry into a result.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_carry_out;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic [WIDTH-1:0] w_sum_next;

    assign w_run      = (r_state == ST_RUN);
    // The returned sum bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
    assign w_sum_next = {fa_sum, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum_out   <= '0;
            r_carry_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_a_sh   <= a_in;
                        r_b_sh   <= b_in;
                        r_c      <= carry_in;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_c      <= fa_carry;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state     <= ST_DONE;
                        r_sum_out   <= w_sum_next;
                        r_carry_out <= fa_carry;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Outside RUN the full adder sees all zeros.
    assign fa_a      = w_run & r_a_sh[0];
    assign fa_b      = w_run & r_b_sh[0];
    assign fa_cin    = w_run & r_c;

    assign busy      = r_busy;
    assign done      = r_done;
    assign sum_out   = r_sum_out;
    assign carry_out = r_carry_out;

endmodule
